// File: rtl/pmac_pkg.sv
// Shared constants and tag type for the pmac scheduler and its datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pmac_pkg;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = $clog2(NUM_REQ);
   localparam int DW      = 8;
   localparam int LAT     = 4;
   localparam int RES_W   = 2 * DW + 1;

   typedef logic [ID_W-1:0] id_t;

   typedef struct packed {
      logic vld;
      id_t  id;
   } tag_t;

endpackage

// File: rtl/pmac_rr_scheduler_if.sv
// Requester, datapath and response signals of the pmac round-robin scheduler.
// Latency: n/a (wiring only).
// Backpressure: per-requester valid/ready; responses have no backpressure.
interface pmac_rr_scheduler_if;
   import pmac_pkg::*;

   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ*DW-1:0] req_a;
   logic [NUM_REQ*DW-1:0] req_b;
   logic [NUM_REQ*DW-1:0] req_c;
   logic [NUM_REQ-1:0]    req_ready;
   logic [DW-1:0]         dp_a;
   logic [DW-1:0]         dp_b;
   logic [DW-1:0]         dp_c;
   logic [RES_W-1:0]      dp_result;
   logic                  rsp_valid;
   logic [ID_W-1:0]       rsp_id;
   logic [RES_W-1:0]      rsp_result;

   // Scheduler side.
   modport slave (
      input  req_valid, req_a, req_b, req_c, dp_result,
      output req_ready, dp_a, dp_b, dp_c, rsp_valid, rsp_id, rsp_result
   );

   // Parent side: requesters, datapath and response consumer.
   modport master (
      output req_valid, req_a, req_b, req_c, dp_result,
      input  req_ready, dp_a, dp_b, dp_c, rsp_valid, rsp_id, rsp_result
   );

endinterface

// File: rtl/pmac_rr_scheduler_rr_arbiter.sv
// Rotating-priority arbiter: first asserted req after ptr (mod NUM_REQ) wins.
// Latency: purely combinational.
// Backpressure: en=0 forces gnt to zero; gnt never depends on request data.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic               en,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] gnt
);

   logic found;
   int   idx;

   // Walk ptr+1, ptr+2, ... wrapping, and grant the first requester seen.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (en && !found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pmac_rr_scheduler.sv
// Round-robin issue of requester ops into a shared LAT-deep (a+b)*c datapath.
// Latency: grant same cycle; response LAT cycles after the transfer, 1 op/cycle.
// Backpressure: one-hot req_ready per requester; responses cannot be stalled.
module pmac_rr_scheduler
   import pmac_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cfg_enable,
   pmac_rr_scheduler_if.slave bus,
   output logic               busy
);

   logic [NUM_REQ-1:0] gnt;
   logic [ID_W-1:0]    gnt_idx;
   logic [ID_W-1:0]    ptr;
   logic               xfer;
   tag_t               tag_q [LAT];

   // Grants are masked during reset so nothing is accepted while rst_n is low.
   rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
      .req (bus.req_valid),
      .en  (cfg_enable & rst_n),
      .ptr (ptr),
      .gnt (gnt)
   );

   assign bus.req_ready = gnt;
   // The arbiter only grants an asserted request, so any grant is a transfer.
   assign xfer          = |gnt;

   // One-hot grant to binary requester index.
   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) gnt_idx = ID_W'(i);
      end
   end

   // Present the granted operands to the datapath; idle cycles drive zeros.
   always_comb begin
      bus.dp_a = '0;
      bus.dp_b = '0;
      bus.dp_c = '0;
      if (xfer) begin
         bus.dp_a = bus.req_a[gnt_idx*DW +: DW];
         bus.dp_b = bus.req_b[gnt_idx*DW +: DW];
         bus.dp_c = bus.req_c[gnt_idx*DW +: DW];
      end
   end

   // Pointer remembers the last winner so the search starts just after it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= ID_W'(NUM_REQ - 1);
      end else if (xfer) begin
         ptr <= gnt_idx;
      end
   end

   // Tag shadow pipeline, aligned stage for stage with the datapath.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < LAT; k++) tag_q[k] <= '0;
      end else begin
         tag_q[0] <= '{vld: xfer, id: gnt_idx};
         for (int k = 1; k < LAT; k++) tag_q[k] <= tag_q[k-1];
      end
   end

   // Busy while any tag stage holds a live op.
   always_comb begin
      busy = 1'b0;
      for (int k = 0; k < LAT; k++) busy = busy | tag_q[k].vld;
   end

   assign bus.rsp_valid  = tag_q[LAT-1].vld;
   assign bus.rsp_id     = tag_q[LAT-1].id;
   assign bus.rsp_result = bus.dp_result;

endmodule
